unified_mem_responder: RTL and testbench
========================================

UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the storage array (power of two).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  instruction-fetch request, held until if_ack.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_rdata  output  32  fetched word, valid while if_ack=1.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 dm_req  input  1  data request, held until dm_ack.
REQ-009 dm_we  input  1  1=store, 0=load.
REQ-010 dm_func3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 dm_addr  input  32  data byte address.
REQ-012 dm_wdata  input  32  store data, right-aligned.
REQ-013 dm_rdata  output  32  load result, valid while dm_ack=1.
REQ-014 dm_ack  output  1  one-cycle data completion pulse.
REQ-015 dm_err  output  1  high with dm_ack when the access was rejected.

Function
REQ-016 FSM states IDLE, BUSY, RESP; IDLE->BUSY on sampled request, BUSY->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 Requests are sampled only in IDLE; req/addr/we/func3/wdata changes in BUSY or RESP are ignored.
REQ-018 In IDLE, dm_req has priority over if_req; a simultaneous if_req stays pending and is served in the next IDLE.
REQ-019 On the IDLE->BUSY edge, port id, address, we, func3 and wdata are latched.
REQ-020 On the BUSY->RESP edge, array read or write is performed and rdata/err registered.
REQ-021 Ack for the granted port is high for exactly the RESP cycle; if_ack and dm_ack are never high together.
REQ-022 Latency: request sampled at edge E0, ack high between E1 and E2; peak throughput one access per 3 cycles.
REQ-023 Requester deasserts req after sampling ack at E2; a req still high at E3 is treated as a new request.
REQ-024 Word index is addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (addresses wrap).
REQ-025 Fetch always reads a full word, ignores addr[1:0] and dm_func3, never errors.
REQ-026 SB writes byte lane addr[1:0]; SH writes halfword lane addr[1]; SW writes full word; other lanes untouched.
REQ-027 LB/LH sign-extend the selected lane; LBU/LHU zero-extend; LW returns the word.
REQ-028 Store ack returns dm_rdata=0, dm_err=0.
REQ-029 Halfword with addr[0]=1, word with addr[1:0]!=0, or func3 in {011,110,111}: no write, dm_rdata=0, dm_err=1.
REQ-030 if_rdata/dm_rdata/dm_err hold 0 whenever the corresponding ack is 0.

Reset
REQ-031 rst=0 immediately forces IDLE, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, dm_err=0, clears latched request.
REQ-032 Storage array contents are not cleared by reset.
REQ-033 Reset asserted in BUSY before the BUSY->RESP edge suppresses the write and the ack; the access is lost.
REQ-034 After rst returns high, the first request is sampled at the first rising edge in IDLE.

Verification
REQ-035 rst=0 mid-stream -> all outputs 0 at once; after release with no req, acks stay 0 for 10 cycles.
REQ-036 SW 0xDEADBEEF @0x10, then LW @0x10 -> dm_ack 2 edges after sampling, dm_rdata=0xDEADBEEF, dm_err=0.
REQ-037 Word 0x11223344 @0x10, SB wdata 0x80 @0x13 -> LB @0x13=0xFFFFFF80, LBU=0x00000080, LW @0x10=0x80223344, LH @0x12=0xFFFF8022.
REQ-038 if_req @0x0 and dm_req LW @0x10 in the same cycle -> dm_ack first, if_ack exactly 3 cycles later with word @0x0.
REQ-039 LW @0x12 -> dm_err=1, dm_rdata=0; SH @0x11 -> dm_err=1, word @0x10 unchanged; func3=011 -> dm_err=1.
REQ-040 SW 0x12345678 @0x1000 (DEPTH_WORDS=1024) -> fetch @0x0 returns 0x12345678; rst=0 during BUSY of SW 0xAAAAAAAA @0x20 -> no ack, word @0x20 unchanged.

Source files
------------

// File: rtl/unified_mem_responder.sv
// Unified instruction/data memory responder.
// Serves one fetch or load/store at a time through a three-state
// IDLE -> BUSY -> RESP sequence. Data requests win over fetches when both
// are present in IDLE. Storage is a word array that survives reset.
module unified_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ack,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [2:0]  i_dm_func3,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic [31:0] o_dm_rdata,
    output logic        o_dm_ack,
    output logic        o_dm_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_next;

    // Latched request; only the byte-address bits that select a word and lane are kept.
    logic            r_port_dm;
    logic [AW+1:0]   r_addr;
    logic            r_we;
    logic [2:0]      r_func3;
    logic [31:0]     r_wdata;

    logic [31:0]     r_if_rdata;
    logic [31:0]     r_dm_rdata;
    logic            r_dm_err;

    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_sample;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_word;
    logic [31:0]     w_shifted;
    logic [15:0]     w_half;
    logic            w_err;
    logic [31:0]     w_load;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata_lane;
    logic            w_wr_en;

    // Address bits above the array size are ignored, so addresses wrap.
    logic            w_unused_addr_bits;
    assign w_unused_addr_bits = ^{i_if_addr[31:AW+2], i_dm_addr[31:AW+2]};

    assign w_sample = (r_state == StIdle) && (i_dm_req || i_if_req);

    // State register; reset drops any access in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the fixed three-cycle access sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_sample) w_state_next = StBusy;
            StBusy:  w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Capture the granted request on the IDLE->BUSY edge; data port has priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_port_dm <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_func3   <= 3'b000;
            r_wdata   <= 32'h0;
        end else if (w_sample) begin
            r_port_dm <= i_dm_req;
            r_addr    <= i_dm_req ? i_dm_addr[AW+1:0] : i_if_addr[AW+1:0];
            r_we      <= i_dm_req && i_dm_we;
            r_func3   <= i_dm_req ? i_dm_func3 : 3'b010;
            r_wdata   <= i_dm_req ? i_dm_wdata : 32'h0;
        end
    end

    assign w_idx     = r_addr[AW+1:2];
    assign w_word    = r_mem[w_idx];
    assign w_shifted = w_word >> {r_addr[1:0], 3'b000};
    assign w_half    = r_addr[1] ? w_word[31:16] : w_word[15:0];

    // Decode size/alignment legality and the load result for the latched data access.
    always_comb begin
        w_err        = 1'b0;
        w_load       = 32'h0;
        w_be         = 4'b0000;
        w_wdata_lane = 32'h0;
        case (r_func3)
            3'b000: begin
                w_load       = {{24{w_shifted[7]}}, w_shifted[7:0]};
                w_be         = 4'b0001 << r_addr[1:0];
                w_wdata_lane = {4{r_wdata[7:0]}};
            end
            3'b100: begin
                w_load = {24'h0, w_shifted[7:0]};
            end
            3'b001: begin
                w_err        = r_addr[0];
                w_load       = {{16{w_half[15]}}, w_half};
                w_be         = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_lane = {2{r_wdata[15:0]}};
            end
            3'b101: begin
                w_err  = r_addr[0];
                w_load = {16'h0, w_half};
            end
            3'b010: begin
                w_err        = (r_addr[1:0] != 2'b00);
                w_load       = w_word;
                w_be         = 4'b1111;
                w_wdata_lane = r_wdata;
            end
            default: w_err = 1'b1;
        endcase
        // Unsigned sizes are load-only; a store with them is not a legal encoding.
        if (r_we && r_func3[2]) begin
            w_err = 1'b1;
        end
    end

    assign w_wr_en = (r_state == StBusy) && r_port_dm && r_we && !w_err;

    // Storage array write on the BUSY->RESP edge; intentionally not reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_wr_en && w_be[b]) begin
                r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
            end
        end
    end

    // Response registers: loaded on BUSY->RESP, cleared after the RESP cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_rdata <= 32'h0;
            r_dm_rdata <= 32'h0;
            r_dm_err   <= 1'b0;
        end else if (r_state == StBusy) begin
            r_if_rdata <= r_port_dm ? 32'h0 : w_word;
            r_dm_rdata <= (r_port_dm && !r_we && !w_err) ? w_load : 32'h0;
            r_dm_err   <= r_port_dm && w_err;
        end else begin
            r_if_rdata <= 32'h0;
            r_dm_rdata <= 32'h0;
            r_dm_err   <= 1'b0;
        end
    end

    assign o_if_ack   = (r_state == StResp) && !r_port_dm;
    assign o_dm_ack   = (r_state == StResp) && r_port_dm;
    assign o_if_rdata = r_if_rdata;
    assign o_dm_rdata = r_dm_rdata;
    assign o_dm_err   = r_dm_err;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench for unified_mem_responder: directed scenarios plus
// randomized traffic against a byte-addressed reference memory.
module tb_unified_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_func3;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        dm_err;

    int errors = 0;
    int checks = 0;

    // Reference memory: 1024 words seen as 4096 bytes, little-endian lanes.
    logic [7:0] mem_b [4096];

    unified_mem_responder #(.DEPTH_WORDS(1024)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_if_req   (if_req),
        .i_if_addr  (if_addr),
        .o_if_rdata (if_rdata),
        .o_if_ack   (if_ack),
        .i_dm_req   (dm_req),
        .i_dm_we    (dm_we),
        .i_dm_func3 (dm_func3),
        .i_dm_addr  (dm_addr),
        .i_dm_wdata (dm_wdata),
        .o_dm_rdata (dm_rdata),
        .o_dm_ack   (dm_ack),
        .o_dm_err   (dm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural effect of one data access on the byte memory.
    task automatic model_dm(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int size;
        int base;
        logic [31:0] v;
        rd = 32'h0;
        er = 1'b0;
        case (f3)
            3'd0:    size = 1;
            3'd4:    size = we ? 0 : 1;
            3'd1:    size = 2;
            3'd5:    size = we ? 0 : 2;
            3'd2:    size = 4;
            default: size = 0;
        endcase
        base = int'(addr[11:0]);
        if (size == 0 || (base % size) != 0) begin
            er = 1'b1;
            return;
        end
        if (we) begin
            for (int i = 0; i < size; i++) mem_b[base + i] = 8'(wd >> (8 * i));
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | ({24'h0, mem_b[base + i]} << (8 * i));
            if (!f3[2] && size < 4 && ((v >> (8 * size - 1)) & 32'h1) == 32'h1)
                v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int base;
        base = int'({addr[11:2], 2'b00});
        return {mem_b[base + 3], mem_b[base + 2], mem_b[base + 1], mem_b[base]};
    endfunction

    // One data access; returns rdata/err and the number of falling edges until ack.
    task automatic dm_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd, output logic er,
                             output int lat);
        @(negedge clk);
        dm_req = 1'b1; dm_we = we; dm_func3 = f3; dm_addr = addr; dm_wdata = wd;
        lat = 0; rd = 32'h0; er = 1'b0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (dm_ack) break;
            check_val("idle_outputs_zero", {dm_rdata | if_rdata}, 32'h0);
        end
        if (!dm_ack) begin
            check_val("dm_ack_timeout", 32'h0, 32'h1);
        end else begin
            rd = dm_rdata;
            er = dm_err;
            check_val("if_ack_during_dm", {31'h0, if_ack}, 32'h0);
        end
        dm_req = 1'b0;
    endtask

    task automatic if_access(input logic [31:0] addr, output logic [31:0] rd, output int lat);
        @(negedge clk);
        if_req = 1'b1; if_addr = addr;
        lat = 0; rd = 32'h0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (if_ack) break;
        end
        if (!if_ack) check_val("if_ack_timeout", 32'h0, 32'h1);
        else begin
            rd = if_rdata;
            check_val("dm_ack_during_if", {31'h0, dm_ack}, 32'h0);
        end
        if_req = 1'b0;
    endtask

    // Data access compared against the reference model, including latency.
    task automatic dm_check(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd, exp_rd;
        logic er, exp_er;
        int lat;
        dm_access(we, f3, addr, wd, rd, er, lat);
        model_dm(we, f3, addr, wd, exp_rd, exp_er);
        check_val({tag, "_rdata"}, rd, exp_rd);
        check_val({tag, "_err"}, {31'h0, er}, {31'h0, exp_er});
        check_val({tag, "_lat"}, lat, 2);
    endtask

    task automatic if_check(input string tag, input logic [31:0] addr);
        logic [31:0] rd;
        int lat;
        if_access(addr, rd, lat);
        check_val({tag, "_rdata"}, rd, model_word(addr));
        check_val({tag, "_lat"}, lat, 2);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat;
        int t, dm_t, if_t, stray;

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_func3 = 3'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        for (int i = 0; i < 4096; i++) mem_b[i] = 8'h0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", {if_rdata | dm_rdata}, 32'h0);
        check_val("reset_flags", {29'h0, if_ack, dm_ack, dm_err}, 32'h0);
        rst_n = 1'b1;

        // Give the first 64 words known contents.
        for (int w = 0; w < 64; w++) dm_check("init_sw", 1'b1, 3'b010, 32'(w * 4), $urandom);

        dm_check("sw_deadbeef", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        dm_access(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        check_val("lw_deadbeef", rd, 32'hDEADBEEF);
        check_val("lw_deadbeef_err", {31'h0, er}, 32'h0);
        check_val("lw_deadbeef_lat", lat, 2);

        // Byte store into an existing word, then all load widths.
        dm_check("sw_11223344", 1'b1, 3'b010, 32'h10, 32'h11223344);
        dm_check("sb_80", 1'b1, 3'b000, 32'h13, 32'h80);
        dm_access(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
        check_val("lb_13", rd, 32'hFFFFFF80);
        dm_access(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
        check_val("lbu_13", rd, 32'h00000080);
        dm_access(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        check_val("lw_10_after_sb", rd, 32'h80223344);
        dm_access(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat);
        check_val("lh_12", rd, 32'hFFFF8022);

        // Simultaneous fetch and load: data first, fetch three cycles later.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_func3 = 3'b010; dm_addr = 32'h10;
        t = 0; dm_t = -1; if_t = -1;
        while (t < 20 && if_t < 0) begin
            @(negedge clk);
            t++;
            check_val("acks_exclusive", {31'h0, if_ack & dm_ack}, 32'h0);
            if (dm_ack && dm_t < 0) begin
                dm_t = t;
                check_val("prio_dm_rdata", dm_rdata, 32'h80223344);
                dm_req = 1'b0;
            end
            if (if_ack) begin
                if_t = t;
                check_val("prio_if_rdata", if_rdata, model_word(32'h0));
                if_req = 1'b0;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        check_val("prio_dm_time", dm_t, 2);
        check_val("prio_if_gap", if_t - dm_t, 3);

        // Rejected accesses leave memory untouched.
        dm_access(1'b0, 3'b010, 32'h12, 32'h0, rd, er, lat);
        check_val("lw_misalign_err", {31'h0, er}, 32'h1);
        check_val("lw_misalign_rdata", rd, 32'h0);
        dm_access(1'b1, 3'b001, 32'h11, 32'hFFFF, rd, er, lat);
        check_val("sh_misalign_err", {31'h0, er}, 32'h1);
        dm_access(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        check_val("sh_misalign_nowrite", rd, 32'h80223344);
        dm_access(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
        check_val("func3_011_err", {31'h0, er}, 32'h1);
        check_val("func3_011_rdata", rd, 32'h0);

        // Address wrap: 0x1000 aliases word 0.
        dm_check("sw_wrap", 1'b1, 3'b010, 32'h1000, 32'h12345678);
        if_access(32'h0, rd, lat);
        check_val("fetch_wrap", rd, 32'h12345678);

        // Reset during BUSY drops the store.
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_func3 = 3'b010; dm_addr = 32'h20; dm_wdata = 32'hAAAAAAAA;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_busy_outputs", {if_rdata | dm_rdata}, 32'h0);
        check_val("rst_busy_flags", {29'h0, if_ack, dm_ack, dm_err}, 32'h0);
        dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_ack || dm_ack) stray++;
        end
        check_val("no_ack_after_reset", stray, 0);
        dm_check("lw_20_unchanged", 1'b0, 3'b010, 32'h20, 32'h0);

        // Reset during the RESP cycle clears outputs immediately.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        repeat (2) @(negedge clk);
        check_val("resp_if_ack_high", {31'h0, if_ack}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_val("rst_resp_outputs", {if_rdata | dm_rdata}, 32'h0);
        check_val("rst_resp_flags", {29'h0, if_ack, dm_ack, dm_err}, 32'h0);
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic within the first 64 words, with random upper address bits.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int kind;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            kind = $urandom_range(0, 3);
            if (kind == 0) if_check("rnd_fetch", a);
            else dm_check("rnd_dm", kind == 1, 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
